// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the sequence RAM player
package seq_pkg;

  localparam int SEQ_WORD_W = 64;
  localparam logic [SEQ_WORD_W-1:0] SEQ_IDLE_WORD = 64'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Repetition counter must never wrap back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_step_timer.sv
// rtl/seq_step_timer.sv - sample tick counter producing the step boundary strobe
module seq_step_timer (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        run,
  input  logic        sample_tick,
  input  logic [31:0] last_cnt,
  output logic        step_tick
);

  logic [31:0] sample_cnt;

  assign step_tick = run && sample_tick && (sample_cnt == last_cnt);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sample_cnt <= '0;
    end else if (!run || step_tick) begin
      sample_cnt <= '0;
    end else if (sample_tick) begin
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/sequence_ram_player.sv
// rtl/sequence_ram_player.sv - steps through a sequence BRAM and presents the current word
module sequence_ram_player
  import seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  sample_tick,
  input  logic [31:0]           samples_per_step,
  input  logic [ADDR_WIDTH:0]   num_steps,
  input  logic [31:0]           num_repetitions,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [SEQ_WORD_W-1:0] bram_rdata,
  output logic [SEQ_WORD_W-1:0] seq_data,
  output logic [ADDR_WIDTH-1:0] step_index,
  output logic                  step_strobe,
  output logic                  running,
  output logic                  done
);

  localparam int SW = ADDR_WIDTH + 1;
  localparam logic [SW-1:0] MAX_STEPS = {1'b1, {ADDR_WIDTH{1'b0}}};

  seq_state_t state, state_next;

  logic [31:0]           sps_last_q;
  logic [SW-1:0]         ns_q;
  logic [31:0]           reps_q;
  logic [31:0]           rep_cnt;
  logic [SW-1:0]         cur_step;
  logic [SEQ_WORD_W-1:0] shadow;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic                  rd_valid;
  logic                  step_tick;

  logic                  bram_en_c;
  logic [ADDR_WIDTH-1:0] bram_addr_c;
  logic                  latch;
  logic                  load;
  logic                  rep_inc;
  logic [SEQ_WORD_W-1:0] load_word;
  logic [SW-1:0]         load_step;
  logic [SW-1:0]         run_next_step;
  logic                  run_wrap;
  logic                  run_finish;

  function automatic logic [SW-1:0] step_after(input logic [SW-1:0] s, input logic [SW-1:0] n);
    return (s == n - SW'(1)) ? '0 : s + SW'(1);
  endfunction

  assign rd_valid = rd_pipe[RD_LATENCY-1];

  seq_step_timer u_timer (
    .clk         (clk),
    .aresetn     (aresetn),
    .run         (state == ST_RUN),
    .sample_tick (sample_tick),
    .last_cnt    (sps_last_q),
    .step_tick   (step_tick)
  );

  assign run_wrap      = (cur_step == ns_q - SW'(1));
  assign run_next_step = step_after(cur_step, ns_q);
  assign run_finish    = run_wrap && (reps_q != 32'd0) && (sat_inc32(rep_cnt) == reps_q);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    bram_en_c   = 1'b0;
    bram_addr_c = '0;
    latch       = 1'b0;
    load        = 1'b0;
    rep_inc     = 1'b0;
    load_word   = SEQ_IDLE_WORD;
    load_step   = '0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_PRIME;
          latch      = 1'b1;
          bram_en_c  = 1'b1;
        end
      end
      ST_PRIME: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else begin
          state_next  = ST_RUN;
          load        = 1'b1;
          load_word   = bram_rdata;
          bram_en_c   = 1'b1;
          bram_addr_c = ADDR_WIDTH'(step_after('0, ns_q));
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (step_tick) begin
          if (run_finish) begin
            state_next = ST_DONE;
          end else begin
            // Word arriving this very cycle bypasses the shadow register.
            load        = 1'b1;
            rep_inc     = run_wrap;
            load_step   = run_next_step;
            load_word   = rd_valid ? bram_rdata : shadow;
            bram_en_c   = 1'b1;
            bram_addr_c = ADDR_WIDTH'(step_after(run_next_step, ns_q));
          end
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sps_last_q  <= '0;
      ns_q        <= '0;
      reps_q      <= '0;
      rep_cnt     <= '0;
      cur_step    <= '0;
      shadow      <= '0;
      rd_pipe     <= '0;
      seq_data    <= SEQ_IDLE_WORD;
      step_strobe <= 1'b0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      rd_pipe[0]  <= bram_en_c;
      step_strobe <= load;
      if (rd_valid) begin
        shadow <= bram_rdata;
      end
      if (latch) begin
        sps_last_q <= (samples_per_step == 32'd0) ? 32'd0 : samples_per_step - 32'd1;
        ns_q       <= (num_steps == '0) ? SW'(1) :
                      (num_steps > MAX_STEPS) ? MAX_STEPS : num_steps;
        reps_q     <= num_repetitions;
        rep_cnt    <= '0;
      end
      if (load) begin
        seq_data <= load_word;
        cur_step <= load_step;
        if (rep_inc) begin
          rep_cnt <= sat_inc32(rep_cnt);
        end
      end else if (state_next != ST_RUN) begin
        seq_data <= SEQ_IDLE_WORD;
        cur_step <= '0;
      end
    end
  end

  assign bram_en    = aresetn && bram_en_c;
  assign bram_addr  = bram_addr_c;
  assign step_index = cur_step[ADDR_WIDTH-1:0];
  assign running    = (state == ST_PRIME) || (state == ST_RUN);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_sequence_ram_player.sv
// tb/tb_sequence_ram_player.sv - self-checking bench for sequence_ram_player
module tb_sequence_ram_player;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic          sample_tick = 1'b0;
  logic [31:0]   samples_per_step = '0;
  logic [AW:0]   num_steps = '0;
  logic [31:0]   num_repetitions = '0;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [63:0]   bram_rdata = '0;
  logic [63:0]   seq_data;
  logic [AW-1:0] step_index;
  logic          step_strobe;
  logic          running;
  logic          done;

  logic [63:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;
  int strobes = 0;

  int          m_phase = M_IDLE;
  int          m_step = 0;
  int unsigned m_ticks = 0;
  int unsigned m_rep = 0;
  int unsigned m_sps = 1;
  int unsigned m_ns = 1;
  int unsigned m_reps = 0;
  logic        m_strobe = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) bram_rdata <= mem[bram_addr];
  end

  sequence_ram_player #(.ADDR_WIDTH(AW), .RD_LATENCY(1)) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .enable           (enable),
    .sample_tick      (sample_tick),
    .samples_per_step (samples_per_step),
    .num_steps        (num_steps),
    .num_repetitions  (num_repetitions),
    .bram_addr        (bram_addr),
    .bram_en          (bram_en),
    .bram_rdata       (bram_rdata),
    .seq_data         (seq_data),
    .step_index       (step_index),
    .step_strobe      (step_strobe),
    .running          (running),
    .done             (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_step   = 0;
    m_strobe = 1'b0;
  endtask

  task automatic model_update(input logic en, input logic tk);
    m_strobe = 1'b0;
    case (m_phase)
      M_IDLE: if (en) begin
        m_phase = M_PRIME;
        m_sps   = (samples_per_step == 0) ? 1 : samples_per_step;
        m_ns    = (num_steps == 0) ? 1 : ((num_steps > DEPTH) ? DEPTH : num_steps);
        m_reps  = num_repetitions;
      end
      M_PRIME: if (!en) m_phase = M_IDLE;
      else begin
        m_phase = M_RUN; m_step = 0; m_ticks = 0; m_rep = 0; m_strobe = 1'b1;
      end
      M_RUN: if (!en) m_phase = M_IDLE;
      else if (tk) begin
        m_ticks++;
        if (m_ticks == m_sps) begin
          m_ticks = 0;
          if (m_step == int'(m_ns) - 1) begin
            m_rep++;
            if (m_reps != 0 && m_rep == m_reps) m_phase = M_DONE;
            else begin m_step = 0; m_strobe = 1'b1; end
          end else begin
            m_step++; m_strobe = 1'b1;
          end
        end
      end
      default: if (!en) m_phase = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    logic [63:0]   exp_data;
    logic [AW-1:0] exp_idx;
    exp_data = (m_phase == M_RUN) ? mem[m_step] : 64'h0;
    exp_idx  = (m_phase == M_RUN) ? m_step[AW-1:0] : '0;
    chk("seq_data", seq_data, exp_data);
    chk("step_index", 64'(step_index), 64'(exp_idx));
    chk("step_strobe", 64'(step_strobe), 64'(m_strobe));
    chk("running", 64'(running), 64'(m_phase == M_PRIME || m_phase == M_RUN));
    chk("done", 64'(done), 64'(m_phase == M_DONE));
  endtask

  task automatic step(input logic en, input logic tk);
    enable = en;
    sample_tick = tk;
    @(posedge clk);
    model_update(en, tk);
    #1;
    if (step_strobe) strobes++;
    check_outputs();
  endtask

  task automatic setup(input int unsigned sps, input int unsigned ns, input int unsigned reps);
    samples_per_step = sps;
    num_steps        = ns[AW:0];
    num_repetitions  = reps;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'(i + 1);

    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    chk("reset_bram_en", 64'(bram_en), 64'h0);
    chk("reset_bram_addr", 64'(bram_addr), 64'h0);
    aresetn = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Two passes of four steps, three ticks each
    setup(3, 4, 2);
    strobes = 0;
    repeat (29) step(1'b1, 1'b1);
    chk("t1_strobe_count", 64'(strobes), 64'd8);
    chk("t1_done", 64'(done), 64'h1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Zero-gap stepping, loop forever
    setup(1, 3, 0);
    repeat (20) step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Never done, index toggles every 5 ticks
    setup(5, 2, 0);
    repeat (102) step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Abort mid-step 2, then restart from step 0
    setup(3, 4, 0);
    repeat (9) step(1'b1, 1'b1);
    chk("abort_pre_index", 64'(step_index), 64'd2);
    step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Asynchronous reset between edges mid-run
    setup(2, 4, 0);
    repeat (7) step(1'b1, 1'b1);
    #3 aresetn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("async_bram_en", 64'(bram_en), 64'h0);
    @(posedge clk);
    #1;
    check_outputs();
    enable = 1'b0;
    aresetn = 1'b1;
    step(1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Zero parameters behave as one step of one tick
    setup(0, 0, 0);
    repeat (10) step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);

    // Step count above the BRAM depth clamps to the full depth
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    setup(1, 2047, 1);
    repeat (DEPTH + 4) step(1'b1, 1'b1);
    chk("clamp_done", 64'(done), 64'h1);
    step(1'b0, 1'b0);

    // Randomized short runs with random tick patterns
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
      setup($urandom_range(0, 4), $urandom_range(1, 6), $urandom_range(0, 3));
      repeat (60) step(1'b1, 1'($urandom_range(0, 1)));
      step(1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_ram_player.md
Name: sequence_ram_player

Overview:
- Upstream feeder of the sequence slicer: steps through a sequence BRAM of 64-bit words and presents the current word as seq_data.
- The slicer splits seq_data into DAC/PDM values, enable flags and dac_reset.
- Advances one step every samples_per_step sample ticks, with wrap-around, repetition counting and a safe all-zero output when not running.

Parameters:
- ADDR_WIDTH, 10, BRAM address width; maximum 2^ADDR_WIDTH steps.
- RD_LATENCY, 1, BRAM read latency in clk cycles; only 1 is supported.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  level; high runs the sequence, low aborts to IDLE
- sample_tick  in  1  one-cycle sample strobe (may be high every cycle)
- samples_per_step  in  32  ticks per step; 0 treated as 1
- num_steps  in  ADDR_WIDTH+1  steps per pass; 0 treated as 1, values >2^ADDR_WIDTH clamp to 2^ADDR_WIDTH
- num_repetitions  in  32  passes before DONE; 0 = loop forever
- bram_addr  out  ADDR_WIDTH  read address
- bram_en  out  1  read enable
- bram_rdata  in  64  read data, valid RD_LATENCY cycles after bram_en
- seq_data  out  64  current sequence word, registered
- step_index  out  ADDR_WIDTH  index of the word on seq_data
- step_strobe  out  1  one-cycle pulse when seq_data changes to a new step
- running  out  1  high in PRIME/RUN
- done  out  1  high in DONE

Behaviour:
- Reset (aresetn low, asynchronous): state IDLE; seq_data=0, step_index=0, bram_addr=0, bram_en=0, step_strobe=0, running=0, done=0; all counters 0.
- Input latching: samples_per_step, num_steps and num_repetitions are latched on the IDLE->PRIME transition. Changes while running are ignored.
- IDLE:
  - seq_data=0, so all slicer enables are 0 and dac_reset is 0.
  - enable=1 -> PRIME with bram_addr=0 and bram_en=1 in the same cycle.
- PRIME:
  - Wait one cycle for bram_rdata.
  - Then seq_data<=bram_rdata, step_index<=0, step_strobe=1, and go to RUN.
  - In that same cycle, issue a prefetch read of address 1 (or 0 if num_steps==1).
- RUN:
  - sample_cnt increments on each sample_tick.
  - Step boundary: sample_tick && sample_cnt==samples_per_step-1. On a boundary, sample_cnt<=0.
  - On a boundary, seq_data<=prefetched word, step_index advances, step_strobe=1, and the prefetch for the following step is issued in the same cycle.
  - Prefetch: the word for step k+1 is read in the cycle step k is loaded. It is captured in a shadow register on the next cycle.
  - Bypass: if a boundary occurs in the capture cycle (samples_per_step==1 with back-to-back ticks), seq_data is taken directly from bram_rdata. Result: zero-gap stepping at one step per clk.
  - Wrap: the step after num_steps-1 is 0, and rep_cnt increments.
  - If num_repetitions!=0 and the wrap would make rep_cnt==num_repetitions: go to DONE instead of loading step 0.
- DONE:
  - seq_data=0, done=1, running=0, bram_en=0.
  - Stays in DONE until enable=0, then IDLE.
- Abort: enable=0 in PRIME or RUN -> IDLE on the next edge; seq_data=0 from that edge. Pending BRAM data is discarded.
- enable re-asserted in the same cycle DONE is reached: stays DONE; a low-high toggle is required to restart.
- Simultaneous events:
  - Abort has priority over a step boundary.
  - Reaching DONE has priority over loading step 0.
- Widths:
  - sample_cnt is 32 bit.
  - rep_cnt is 32 bit and saturates; it never wraps back to 0.
  - Step counter is ADDR_WIDTH+1 bit, so num_steps==2^ADDR_WIDTH is exact.

Decomposition:
- Shared package (seq_pkg):
  - SEQ_WORD_W=64
  - state encoding ST_IDLE/ST_PRIME/ST_RUN/ST_DONE
  - SEQ_IDLE_WORD=64'h0
- One sub-module: seq_step_timer, which holds sample_cnt and boundary detection and outputs step_tick. The FSM and prefetch/bypass logic stay at top level.

Test Plan:
- BRAM[i]=i+1, num_steps=4, samples_per_step=3, num_repetitions=2, tick every cycle -> seq_data sequence 1,2,3,4,1,2,3,4 with each value held 3 ticks; step_strobe 8 times; then done=1 and seq_data=0.
- samples_per_step=1, ticks every cycle, num_steps=3, num_repetitions=0 -> seq_data 1,2,3,1,2,3... with a new value every clk and no repeated or skipped word (checks bypass).
- num_repetitions=0, num_steps=2, samples_per_step=5, run 100 ticks -> never done; step_index toggles 0/1 every 5 ticks.
- enable dropped mid-step 2 -> seq_data=0 and running=0 on the next clk; re-enable -> restarts at step 0 after the PRIME cycle.
- aresetn pulsed low asynchronously mid-run (between clk edges) -> seq_data=0 immediately; all outputs at reset values until aresetn high and enable re-asserted.
- samples_per_step=0 and num_steps=0 latched -> behaves as 1/1: seq_data=BRAM[0] reloaded every tick; step_strobe every tick.
